// File: rtl/code_entry.sv
// Keypad front-end for the combination lock: buffers BCD digits, compares them to the
// stored code and strobes Enter/Change/Password. Optional idle timeout: ENTRY_TIMEOUT_EN.
module code_entry #(
    parameter int                  DIGITS         = 4,
    parameter logic [DIGITS*4-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int                  TIMEOUT_CYCLES = 1000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Key_Valid,
    input  logic [3:0] Key_Code,
    input  logic       Enter_Key,
    input  logic       Change_Key,
    input  logic       New,
    output logic       Enter,
    output logic       Change,
    output logic       Password,
    output logic [3:0] Digit_Count,
    output logic       Code_Saved
);

    // state   | meaning
    // COLLECT | accepting digit keys, waiting for Enter/Change
    // COMMIT  | one cycle, strobes to the lock are high; entry cleared on exit
    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_COMMIT  = 1'b1
    } state_t;

    localparam int         W        = DIGITS * 4;
    localparam logic [3:0] DIGITS_C = 4'(DIGITS);

    state_t         state_q, state_d;
    logic [W-1:0]   buf_q, buf_d;
    logic [W-1:0]   code_q, code_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           ovr_q, ovr_d;
    logic           enter_q, enter_d;
    logic           change_q, change_d;
    logic           pass_q, pass_d;
    logic           saved_q, saved_d;

    logic full, match, upd, commit_req, digit_ok;

    assign full       = (cnt_q == DIGITS_C);
    assign match      = full && !ovr_q && (buf_q == code_q);
    assign upd        = New && full && !ovr_q;
    assign commit_req = Enter_Key || Change_Key;
    assign digit_ok   = Key_Valid && (Key_Code <= 4'd9);

`ifdef ENTRY_TIMEOUT_EN
    localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_q, to_d;
    logic          to_fire;

    always_comb begin
        to_d    = '0;
        to_fire = 1'b0;
        if (state_q == ST_COLLECT && cnt_q != 4'd0 && !Key_Valid && !commit_req) begin
            if (to_q == TO_LAST) begin
                to_fire = 1'b1;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) to_q <= '0;
        else       to_q <= to_d;
    end
`endif

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;
        code_d   = code_q;
        enter_d  = 1'b0;
        change_d = 1'b0;
        pass_d   = 1'b0;
        saved_d  = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (commit_req) begin
                    state_d  = ST_COMMIT;
                    enter_d  = Enter_Key;
                    change_d = !Enter_Key;
                    // A code change never opens the lock on the same commit.
                    pass_d   = match && !upd;
                    saved_d  = upd;
                    if (upd) code_d = buf_q;
                end else if (digit_ok) begin
                    if (full) begin
                        ovr_d = 1'b1;
                    end else begin
                        buf_d = (buf_q << 4) | W'(Key_Code);
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`ifdef ENTRY_TIMEOUT_EN
                if (to_fire) begin
                    buf_d = '0;
                    cnt_d = 4'd0;
                    ovr_d = 1'b0;
                end
`endif
            end
            ST_COMMIT: begin
                state_d = ST_COLLECT;
                buf_d   = '0;
                cnt_d   = 4'd0;
                ovr_d   = 1'b0;
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_COLLECT;
            buf_q    <= '0;
            code_q   <= DEFAULT_CODE;
            cnt_q    <= 4'd0;
            ovr_q    <= 1'b0;
            enter_q  <= 1'b0;
            change_q <= 1'b0;
            pass_q   <= 1'b0;
            saved_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            enter_q  <= enter_d;
            change_q <= change_d;
            pass_q   <= pass_d;
            saved_q  <= saved_d;
        end
    end

    assign Enter       = enter_q;
    assign Change      = change_q;
    assign Password    = pass_q;
    assign Code_Saved  = saved_q;
    assign Digit_Count = cnt_q;

endmodule

// File: tb/tb_code_entry.sv
// Bench for code_entry: vector table plus hand sequences for reset and timeout corners.
// Build with ENTRY_TIMEOUT_EN defined to exercise the idle timeout.
module tb_code_entry;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Key_Valid, Enter_Key, Change_Key, New;
    logic [3:0] Key_Code;
    logic       Enter, Change, Password, Code_Saved;
    logic [3:0] Digit_Count;

    code_entry #(
        .DIGITS        (4),
        .DEFAULT_CODE  (16'h1234),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Key_Valid  (Key_Valid),
        .Key_Code   (Key_Code),
        .Enter_Key  (Enter_Key),
        .Change_Key (Change_Key),
        .New        (New),
        .Enter      (Enter),
        .Change     (Change),
        .Password   (Password),
        .Digit_Count(Digit_Count),
        .Code_Saved (Code_Saved)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic       ek, ck, nw;
        logic       en, ch, pw, sv;
        logic [3:0] cnt;
    } vec_t;

    typedef struct {
        logic       en, ch, pw, sv;
        logic [3:0] cnt;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, queue the expectation, sample just after the edge.
    task automatic step(input logic kv, input logic [3:0] kc, input logic ek, input logic ck,
                        input logic nw, input logic en, input logic ch, input logic pw,
                        input logic sv, input logic [3:0] cnt, input string tag);
        exp_t e;
        Key_Valid  = kv;
        Key_Code   = kc;
        Enter_Key  = ek;
        Change_Key = ck;
        New        = nw;
        e = '{en, ch, pw, sv, cnt, tag};
        sb.push_back(e);
        @(posedge Clock);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".enter"},  {3'b0, Enter},      {3'b0, e.en});
        chk({e.tag, ".change"}, {3'b0, Change},     {3'b0, e.ch});
        chk({e.tag, ".pass"},   {3'b0, Password},   {3'b0, e.pw});
        chk({e.tag, ".saved"},  {3'b0, Code_Saved}, {3'b0, e.sv});
        chk({e.tag, ".count"},  Digit_Count,        e.cnt);
    endtask

    task automatic add(input logic kv, input logic [3:0] kc, input logic ek, input logic ck,
                       input logic nw, input logic en, input logic ch, input logic pw,
                       input logic sv, input logic [3:0] cnt);
        vecs.push_back('{kv, kc, ek, ck, nw, en, ch, pw, sv, cnt});
    endtask

    task automatic add_key(input logic [3:0] d, input logic [3:0] cnt);
        add(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
    endtask

    task automatic add_idle(input logic [3:0] cnt);
        add(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
    endtask

    task automatic add_cmt(input logic ek, input logic ck, input logic nw, input logic en,
                           input logic ch, input logic pw, input logic sv, input logic [3:0] cnt);
        add(1'b0, 4'd0, ek, ck, nw, en, ch, pw, sv, cnt);
    endtask

    task automatic add_code(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] d);
        add_key(a, 4'd1); add_key(b, 4'd2); add_key(c, 4'd3); add_key(d, 4'd4);
    endtask

    task automatic key(input logic [3:0] d, input logic [3:0] cnt, input string tag);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt, tag);
    endtask

    task automatic idle(input logic [3:0] cnt, input string tag);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt, tag);
    endtask

    initial begin
        Reset = 1'b1; Key_Valid = 0; Key_Code = 0; Enter_Key = 0; Change_Key = 0; New = 0;
        #12;
        chk("rst.enter",  {3'b0, Enter},      4'd0);
        chk("rst.change", {3'b0, Change},     4'd0);
        chk("rst.pass",   {3'b0, Password},   4'd0);
        chk("rst.saved",  {3'b0, Code_Saved}, 4'd0);
        chk("rst.count",  Digit_Count,        4'd0);
        @(posedge Clock); #1;
        Reset = 1'b0;

        // correct code opens
        add_code(1, 2, 3, 4); add_cmt(1, 0, 0, 1, 0, 1, 0, 4); add_idle(0);
        // wrong code, then overrun
        add_code(1, 2, 3, 5); add_cmt(1, 0, 0, 1, 0, 0, 0, 4); add_idle(0);
        add_code(1, 2, 3, 4); add_key(5, 4); add_cmt(1, 0, 0, 1, 0, 0, 0, 4); add_idle(0);
        // code change to 9876, then old code no longer matches
        add_code(9, 8, 7, 6); add_cmt(1, 0, 1, 1, 0, 0, 1, 4); add_idle(0);
        add_code(9, 8, 7, 6); add_cmt(1, 0, 0, 1, 0, 1, 0, 4); add_idle(0);
        add_code(1, 2, 3, 4); add_cmt(1, 0, 0, 1, 0, 0, 0, 4); add_idle(0);
        // Enter wins over Change; key during COMMIT ignored
        add_code(9, 8, 7, 6); add_cmt(1, 1, 0, 1, 0, 1, 0, 4);
        add(1, 4'd1, 0, 0, 0, 0, 0, 0, 0, 0); add_idle(0);
        // Change alone
        add_code(9, 8, 7, 6); add_cmt(0, 1, 0, 0, 1, 1, 0, 4); add_idle(0);
        // incomplete entry with New=1 keeps stored code
        add_key(1, 1); add_key(2, 2); add_cmt(0, 1, 1, 0, 1, 0, 0, 2); add_idle(0);
        add_code(9, 8, 7, 6); add_cmt(1, 0, 0, 1, 0, 1, 0, 4); add_idle(0);
        // overrun entry with New=1 keeps stored code
        add_code(5, 5, 5, 5); add_key(5, 4); add_cmt(1, 0, 1, 1, 0, 0, 0, 4); add_idle(0);
        add_code(9, 8, 7, 6); add_cmt(1, 0, 0, 1, 0, 1, 0, 4); add_idle(0);
        // non-digit key code ignored
        add_key(5, 1); add_key(12, 1); add_idle(1); add_cmt(1, 0, 0, 1, 0, 0, 0, 1); add_idle(0);
        // empty entry
        add_cmt(1, 0, 0, 1, 0, 0, 0, 0); add_idle(0);
        // Enter drops same-cycle digit
        add_code(9, 8, 7, 6); add(1, 4'd5, 1, 0, 0, 1, 0, 1, 0, 4); add_idle(0);
        // Enter during COMMIT ignored
        add_code(9, 8, 7, 6); add_cmt(1, 0, 0, 1, 0, 1, 0, 4);
        add_cmt(1, 0, 0, 0, 0, 0, 0, 0); add_idle(0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].kv, vecs[i].kc, vecs[i].ek, vecs[i].ck, vecs[i].nw,
                 vecs[i].en, vecs[i].ch, vecs[i].pw, vecs[i].sv, vecs[i].cnt,
                 $sformatf("v%0d", i));
        end

        // reset mid-entry clears buffer and restores default code
        key(1, 1, "t5.k1"); key(2, 2, "t5.k2");
        Key_Valid = 0; Reset = 1'b1; #1;
        chk("t5.rst_count", Digit_Count, 4'd0);
        @(posedge Clock); #1; Reset = 1'b0;
        key(3, 1, "t5.k3"); key(4, 2, "t5.k4");
        step(0, 0, 1, 0, 0, 1, 0, 0, 0, 2, "t5.enter"); idle(0, "t5.idle");
        key(1, 1, "t5.d1"); key(2, 2, "t5.d2"); key(3, 3, "t5.d3"); key(4, 4, "t5.d4");
        step(0, 0, 1, 0, 0, 1, 0, 1, 0, 4, "t5.default"); idle(0, "t5.idle2");

        // reset in COMMIT clears strobes immediately
        key(1, 1, "rc.k1"); key(2, 2, "rc.k2"); key(3, 3, "rc.k3"); key(4, 4, "rc.k4");
        step(0, 0, 1, 0, 0, 1, 0, 1, 0, 4, "rc.enter");
        Enter_Key = 0; Reset = 1'b1; #1;
        chk("rc.enter",  {3'b0, Enter},    4'd0);
        chk("rc.pass",   {3'b0, Password}, 4'd0);
        @(posedge Clock); #1; Reset = 1'b0;

        // update pending but reset arrives before the edge: stored code stays default
        key(5, 1, "rp.k5"); key(6, 2, "rp.k6"); key(7, 3, "rp.k7"); key(8, 4, "rp.k8");
        Key_Valid = 0; Enter_Key = 1; New = 1; #2;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0; Enter_Key = 0; New = 0;
        chk("rp.saved", {3'b0, Code_Saved}, 4'd0);
        key(5, 1, "rp.n5"); key(6, 2, "rp.n6"); key(7, 3, "rp.n7"); key(8, 4, "rp.n8");
        step(0, 0, 1, 0, 0, 1, 0, 0, 0, 4, "rp.new_code"); idle(0, "rp.idle");
        key(1, 1, "rp.d1"); key(2, 2, "rp.d2"); key(3, 3, "rp.d3"); key(4, 4, "rp.d4");
        step(0, 0, 1, 0, 0, 1, 0, 1, 0, 4, "rp.default"); idle(0, "rp.idle2");

`ifdef ENTRY_TIMEOUT_EN
        key(1, 1, "to.k1");
        for (int i = 0; i < 7; i++) idle(1, $sformatf("to.wait%0d", i));
        idle(0, "to.expire");
        key(1, 1, "to.k1b");
        for (int i = 0; i < 7; i++) idle(1, $sformatf("to.hold%0d", i));
        key(2, 2, "to.k2");
        step(0, 0, 1, 0, 0, 1, 0, 0, 0, 2, "to.flush"); idle(0, "to.idle");
`else
        key(1, 1, "nt.k1");
        for (int i = 0; i < 20; i++) idle(1, $sformatf("nt.wait%0d", i));
        step(0, 0, 1, 0, 0, 1, 0, 0, 0, 1, "nt.flush"); idle(0, "nt.idle");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
